// File: rtl/l2_pkg.sv
// Shared types for the L2 arbiter: FSM state encoding and requester-id width.
package l2_pkg;

  localparam int REQ_ID_W = 1;

  typedef logic [REQ_ID_W-1:0] req_id_t;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin picker: on a tie the requester that did
// not win last time is chosen.
module rr_arb2
  import l2_pkg::*;
(
  input  logic [1:0] req,
  input  req_id_t    last_grant,
  output logic       gnt_valid,
  output req_id_t    gnt_id
);

  always_comb begin
    gnt_valid = |req;
    gnt_id    = '0;
    if (req == 2'b11) begin
      gnt_id = ~last_grant;
    end else if (req[1]) begin
      gnt_id = req_id_t'(1);
    end
  end

endmodule

// File: rtl/l2_arbiter.sv
// Two-requester round-robin arbiter in front of a shared L2 port.
// Define L2_ARB_PERF_EN to add per-requester completed-transaction counters.
module l2_arbiter
  import l2_pkg::*;
#(
  parameter  int DATA_WIDTH = 32,
  parameter  int ADDR_WIDTH = 32,
  parameter  int BLOCK_SIZE = 16,
  localparam int BW         = BLOCK_SIZE * DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] r0_addr,
  input  logic [BW-1:0]         r0_wdata,
  input  logic                  r0_read,
  input  logic                  r0_write,
  output logic                  r0_ready,
  output logic                  r0_hit,
  output logic [BW-1:0]         r0_rdata,
  output logic                  r0_rvalid,
  input  logic [ADDR_WIDTH-1:0] r1_addr,
  input  logic [BW-1:0]         r1_wdata,
  input  logic                  r1_read,
  input  logic                  r1_write,
  output logic                  r1_ready,
  output logic                  r1_hit,
  output logic [BW-1:0]         r1_rdata,
  output logic                  r1_rvalid,
  output logic [ADDR_WIDTH-1:0] l2_addr,
  output logic [BW-1:0]         l2_wdata,
  output logic                  l2_read,
  output logic                  l2_write,
  input  logic                  l2_ready,
  input  logic                  l2_hit,
  input  logic [BW-1:0]         l2_rdata,
  input  logic                  l2_rvalid
`ifdef L2_ARB_PERF_EN
  ,
  output logic [15:0]           grant_cnt0,
  output logic [15:0]           grant_cnt1
`endif
);

  arb_state_e            state_q, state_d;
  req_id_t               last_grant_q, last_grant_d;
  req_id_t               gnt_id_q, gnt_id_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [BW-1:0]         wdata_q, wdata_d;
  logic                  read_q, read_d;
  logic                  write_q, write_d;

  logic [1:0] req;
  logic       arb_valid;
  req_id_t    arb_id;
  logic       done;
  logic [1:0] rdy_vec;
  logic [1:0] hit_vec;
  logic [1:0] rvalid_vec;
  logic [BW-1:0] rdata_vec [2];

  assign req = {r1_read | r1_write, r0_read | r0_write};

  rr_arb2 u_rr_arb2 (
    .req        (req),
    .last_grant (last_grant_q),
    .gnt_valid  (arb_valid),
    .gnt_id     (arb_id)
  );

  // l2_ready only means something while a transaction is in flight.
  assign done = (state_q == BUSY) && l2_ready;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    gnt_id_d     = gnt_id_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    read_d       = read_q;
    write_d      = write_q;
    case (state_q)
      IDLE: begin
        if (arb_valid) begin
          state_d      = BUSY;
          gnt_id_d     = arb_id;
          last_grant_d = arb_id;
          if (arb_id == req_id_t'(1)) begin
            addr_d  = r1_addr;
            wdata_d = r1_wdata;
            read_d  = r1_read;
            write_d = r1_write;
          end else begin
            addr_d  = r0_addr;
            wdata_d = r0_wdata;
            read_d  = r0_read;
            write_d = r0_write;
          end
        end
      end
      BUSY: begin
        if (l2_ready) begin
          state_d = IDLE;
          read_d  = 1'b0;
          write_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= req_id_t'(1);
      gnt_id_q     <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      read_q       <= 1'b0;
      write_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      gnt_id_q     <= gnt_id_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      read_q       <= read_d;
      write_q      <= write_d;
    end
  end

  assign l2_addr  = addr_q;
  assign l2_wdata = wdata_q;
  assign l2_read  = read_q;
  assign l2_write = write_q;

  // The L2 response is routed only to the owner, and only in its completion cycle.
  for (genvar gi = 0; gi < 2; gi++) begin : g_resp
    assign rdy_vec[gi]    = done && (gnt_id_q == req_id_t'(gi));
    assign hit_vec[gi]    = rdy_vec[gi] & l2_hit;
    assign rvalid_vec[gi] = rdy_vec[gi] & l2_rvalid;
    assign rdata_vec[gi]  = rdy_vec[gi] ? l2_rdata : '0;
  end

  assign r0_ready  = rdy_vec[0];
  assign r0_hit    = hit_vec[0];
  assign r0_rvalid = rvalid_vec[0];
  assign r0_rdata  = rdata_vec[0];
  assign r1_ready  = rdy_vec[1];
  assign r1_hit    = hit_vec[1];
  assign r1_rvalid = rvalid_vec[1];
  assign r1_rdata  = rdata_vec[1];

`ifdef L2_ARB_PERF_EN
  for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
    logic [15:0] cnt_q, cnt_d;

    always_comb begin
      cnt_d = cnt_q;
      if (rdy_vec[gi] && (cnt_q != 16'hFFFF)) begin
        cnt_d = cnt_q + 16'd1;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end
  end

  assign grant_cnt0 = g_cnt[0].cnt_q;
  assign grant_cnt1 = g_cnt[1].cnt_q;
`endif

endmodule

// File: tb/tb_l2_arbiter.sv
// Randomized scoreboard bench for l2_arbiter: two requester agents, an L2
// responder, a grant-order reference model and a decoupled output monitor.
module tb_l2_arbiter;

  localparam int DW    = 32;
  localparam int AW    = 32;
  localparam int BS    = 16;
  localparam int BW    = DW * BS;
  localparam int N_TXN = 60;

  typedef struct {
    int          id;
    logic [AW-1:0] addr;
    logic [BW-1:0] wdata;
    logic        rd;
    logic        wr;
    int          gcyc;
  } txn_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [AW-1:0] q_addr  [2];
  logic [BW-1:0] q_wdata [2];
  logic          q_rd    [2];
  logic          q_wr    [2];

  logic          r0_ready, r0_hit, r0_rvalid, r1_ready, r1_hit, r1_rvalid;
  logic [BW-1:0] r0_rdata, r1_rdata;
  logic [AW-1:0] l2_addr;
  logic [BW-1:0] l2_wdata;
  logic          l2_read, l2_write;
  logic          l2_ready, l2_hit, l2_rvalid;
  logic [BW-1:0] l2_rdata;
`ifdef L2_ARB_PERF_EN
  logic [15:0]   grant_cnt0, grant_cnt1;
`endif

  l2_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BLOCK_SIZE(BS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .r0_addr   (q_addr[0]),
    .r0_wdata  (q_wdata[0]),
    .r0_read   (q_rd[0]),
    .r0_write  (q_wr[0]),
    .r0_ready  (r0_ready),
    .r0_hit    (r0_hit),
    .r0_rdata  (r0_rdata),
    .r0_rvalid (r0_rvalid),
    .r1_addr   (q_addr[1]),
    .r1_wdata  (q_wdata[1]),
    .r1_read   (q_rd[1]),
    .r1_write  (q_wr[1]),
    .r1_ready  (r1_ready),
    .r1_hit    (r1_hit),
    .r1_rdata  (r1_rdata),
    .r1_rvalid (r1_rvalid),
    .l2_addr   (l2_addr),
    .l2_wdata  (l2_wdata),
    .l2_read   (l2_read),
    .l2_write  (l2_write),
    .l2_ready  (l2_ready),
    .l2_hit    (l2_hit),
    .l2_rdata  (l2_rdata),
    .l2_rvalid (l2_rvalid)
`ifdef L2_ARB_PERF_EN
    ,
    .grant_cnt0 (grant_cnt0),
    .grant_cnt1 (grant_cnt1)
`endif
  );

  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;
  int   n_done   = 0;
  bit   start    = 1'b0;
  bit   fin [2]  = '{1'b0, 1'b0};
  txn_t exp_q [$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end else begin
      n_pass++;
    end
  endtask

  function automatic logic [BW-1:0] rand_blk();
    logic [BW-1:0] v;
    for (int i = 0; i < BS; i++) v[i*DW +: DW] = $urandom;
    return v;
  endfunction

  task automatic check_all_zero(input string tag);
    chk({tag, "_l2_read"},   l2_read,   0);
    chk({tag, "_l2_write"},  l2_write,  0);
    chk({tag, "_l2_addr"},   l2_addr,   0);
    chk({tag, "_l2_wdata"},  l2_wdata,  0);
    chk({tag, "_r0_ready"},  r0_ready,  0);
    chk({tag, "_r1_ready"},  r1_ready,  0);
    chk({tag, "_r_hit"},     {r0_hit, r1_hit}, 0);
    chk({tag, "_r_rvalid"},  {r0_rvalid, r1_rvalid}, 0);
    chk({tag, "_r0_rdata"},  r0_rdata,  0);
    chk({tag, "_r1_rdata"},  r1_rdata,  0);
  endtask

  // Requester agent: level request held until its ready pulse, dropped the
  // next cycle; addr/wdata are scrambled while waiting to prove they are latched.
  task automatic requester(input int n);
    bit done;
    int kind;
    wait (start);
    for (int k = 0; k < N_TXN; k++) begin
      repeat ($urandom_range(1, 3)) begin
        @(posedge clk);
        #1;
      end
      kind       = $urandom_range(1, 3);
      q_rd[n]    = kind[0];
      q_wr[n]    = kind[1];
      q_addr[n]  = $urandom;
      q_wdata[n] = rand_blk();
      done       = 1'b0;
      while (!done) begin
        @(negedge clk);
        if (rst_n && ((n == 0) ? r0_ready : r1_ready)) done = 1'b1;
        @(posedge clk);
        #1;
        if (!done && ($urandom_range(0, 3) == 0)) begin
          q_addr[n]  = $urandom;
          q_wdata[n] = rand_blk();
        end
      end
      q_rd[n] = 1'b0;
      q_wr[n] = 1'b0;
    end
    fin[n] = 1'b1;
  endtask

  initial requester(0);
  initial requester(1);

  // L2 responder: random 0..3 cycle latency, random response, spurious
  // l2_ready pulses while nothing is outstanding.
  initial begin
    bit resp_active;
    int dly;
    resp_active = 1'b0;
    dly         = 0;
    l2_ready    = 1'b0;
    l2_hit      = 1'b0;
    l2_rvalid   = 1'b0;
    l2_rdata    = '0;
    forever begin
      @(posedge clk);
      #1;
      l2_hit    = 1'($urandom);
      l2_rvalid = 1'($urandom);
      l2_rdata  = rand_blk();
      if (l2_read || l2_write) begin
        if (!resp_active) begin
          resp_active = 1'b1;
          dly         = $urandom_range(0, 3);
        end
        if (dly == 0) begin
          l2_ready = 1'b1;
        end else begin
          l2_ready = 1'b0;
          dly--;
        end
      end else begin
        resp_active = 1'b0;
        l2_ready    = ($urandom_range(0, 3) == 0);
      end
    end
  end

  // Reference model: one grant per idle cycle, tie goes to whoever did not
  // win last, each grant occupies the L2 until its l2_ready.
  initial begin
    int   last;
    bit   mbusy;
    bit   p0, p1;
    int   pick;
    txn_t t;
    last  = 1;
    mbusy = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        last  = 1;
        mbusy = 1'b0;
      end else if (mbusy) begin
        if (l2_ready) mbusy = 1'b0;
      end else begin
        p0 = q_rd[0] | q_wr[0];
        p1 = q_rd[1] | q_wr[1];
        if (p0 || p1) begin
          pick    = (p0 && p1) ? (1 - last) : (p0 ? 0 : 1);
          t.id    = pick;
          t.addr  = q_addr[pick];
          t.wdata = q_wdata[pick];
          t.rd    = q_rd[pick];
          t.wr    = q_wr[pick];
          t.gcyc  = cyc;
          exp_q.push_back(t);
          last    = pick;
          mbusy   = 1'b1;
        end
      end
    end
  end

  // Monitor: pops an expected grant when the L2 bus starts a transaction and
  // checks the bus and the requester-side response against it.
  initial begin
    txn_t cur;
    bit   cur_valid;
    int   ref_cnt [2];
    cur_valid  = 1'b0;
    ref_cnt[0] = 0;
    ref_cnt[1] = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        cur_valid = 1'b0;
        exp_q.delete();
        chk("ready_in_reset", {r0_ready, r1_ready}, 0);
        ref_cnt[0] = 0;
        ref_cnt[1] = 0;
        continue;
      end
`ifdef L2_ARB_PERF_EN
      chk("grant_cnt0", grant_cnt0, ref_cnt[0]);
      chk("grant_cnt1", grant_cnt1, ref_cnt[1]);
`endif
      if (!cur_valid && (l2_read || l2_write)) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_grant", 1, 0);
        end else begin
          cur       = exp_q.pop_front();
          cur_valid = 1'b1;
          chk("grant_latency", cyc, cur.gcyc + 1);
        end
      end
      if (cur_valid) begin
        chk("l2_addr",  l2_addr,  cur.addr);
        chk("l2_wdata", l2_wdata, cur.wdata);
        chk("l2_read",  l2_read,  cur.rd);
        chk("l2_write", l2_write, cur.wr);
        chk("r0_ready", r0_ready, l2_ready && (cur.id == 0));
        chk("r1_ready", r1_ready, l2_ready && (cur.id == 1));
        if (l2_ready) begin
          if (cur.id == 0) begin
            chk("r0_hit",    r0_hit,    l2_hit);
            chk("r0_rvalid", r0_rvalid, l2_rvalid);
            chk("r0_rdata",  r0_rdata,  l2_rdata);
            chk("r1_quiet",  {r1_hit, r1_rvalid, r1_rdata}, 0);
          end else begin
            chk("r1_hit",    r1_hit,    l2_hit);
            chk("r1_rvalid", r1_rvalid, l2_rvalid);
            chk("r1_rdata",  r1_rdata,  l2_rdata);
            chk("r0_quiet",  {r0_hit, r0_rvalid, r0_rdata}, 0);
          end
          $display("txn %0d: req%0d rd=%0b wr=%0b addr=%08h hit=%0b", n_done, cur.id,
                   cur.rd, cur.wr, cur.addr, l2_hit);
          ref_cnt[cur.id]++;
          n_done++;
          cur_valid = 1'b0;
        end
      end else begin
        chk("idle_outputs", {r0_ready, r1_ready, r0_hit, r1_hit, r0_rvalid, r1_rvalid}, 0);
      end
    end
  end

  initial begin
    int guard;
    bit hit_busy;
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      q_addr[i]  = '0;
      q_wdata[i] = '0;
      q_rd[i]    = 1'b0;
      q_wr[i]    = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;
    start = 1'b1;

    // Abort a transaction mid-flight once traffic is under way.
    while (cyc < 120) @(posedge clk);
    hit_busy = 1'b0;
    guard    = 0;
    while (!hit_busy && guard < 200) begin
      @(posedge clk);
      #2;
      if ((l2_read || l2_write) && !l2_ready) hit_busy = 1'b1;
      guard++;
    end
    chk("found_busy_for_abort", hit_busy, 1);
    rst_n = 1'b0;
    #1;
    check_all_zero("abort");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    guard = 0;
    while (!(fin[0] && fin[1]) && guard < 20000) begin
      @(posedge clk);
      guard++;
    end
    chk("all_txn_done", {fin[0], fin[1]}, 2'b11);
    repeat (3) @(posedge clk);
    chk("completions", n_done, 2 * N_TXN);
    chk("exp_queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/l2_arbiter.md
L2_ARBITER -- requirements
Module: l2_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 32: word width in bits.
REQ-002 Parameter ADDR_WIDTH, default 32: address width in bits.
REQ-003 Parameter BLOCK_SIZE, default 16: words per block; block bus width BW = BLOCK_SIZE*DATA_WIDTH.
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset, with ports clk and rst_n.
REQ-005 clk  input  1  clock; all state updates on its rising edge.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 For each requester n in {0,1}, the block SHALL have these ports:
- rN_addr  input  ADDR_WIDTH  request address.
- rN_wdata  input  BW  write block.
- rN_read  input  1  read request, level.
- rN_write  input  1  write request, level.
- rN_ready  output  1  transaction complete, one-cycle pulse.
- rN_hit  output  1  L2 hit, valid with rN_ready.
- rN_rdata  output  BW  read block, valid with rN_ready.
- rN_rvalid  output  1  read block valid.
REQ-008 Downstream (L2) port:
- l2_addr  output  ADDR_WIDTH  address.
- l2_wdata  output  BW  write block.
- l2_read  output  1  read request.
- l2_write  output  1  write request.
- l2_ready  input  1  L2 done.
- l2_hit  input  1  L2 hit.
- l2_rdata  input  BW  L2 read block.
- l2_rvalid  input  1  L2 block valid.

Function
REQ-009 The FSM SHALL have states IDLE and BUSY.
REQ-010 IDLE: if any rN_read|rN_write is asserted, the FSM SHALL grant one requester, latch its addr/wdata/read/write into registers, and enter BUSY on the next edge.
REQ-011 Arbitration SHALL be round-robin using a last_grant register: on simultaneous requests, the requester not equal to last_grant wins. last_grant SHALL update on each grant.
REQ-012 BUSY: l2_addr/l2_wdata/l2_read/l2_write SHALL be driven from the latched registers and held constant until l2_ready=1.
REQ-013 In the BUSY cycle with l2_ready=1, the block SHALL:
- drive the granted rN_ready=1;
- drive rN_hit=l2_hit, rN_rvalid=l2_rvalid and rN_rdata=l2_rdata combinationally;
- return to IDLE on the next edge.
REQ-014 The non-granted requester's outputs SHALL be 0 at all times. Its request SHALL remain pending and is not dropped.
REQ-015 Latency: from a request sampled in IDLE, l2_read/l2_write SHALL assert 1 cycle later. rN_ready SHALL assert in the same cycle as l2_ready.
REQ-016 A requester SHALL deassert its request the cycle after rN_ready. The arbiter SHALL spend at least one IDLE cycle between grants.
REQ-017 If rN_read and rN_write are both set, both SHALL be forwarded unchanged.
REQ-018 Changes on the granted requester's inputs during BUSY SHALL be ignored.
REQ-019 l2_ready while in IDLE SHALL be ignored.

Reset
REQ-020 While rst_n=0, the block SHALL:
- set the FSM to IDLE and last_grant=1, so requester 0 wins first;
- clear all latched registers;
- drive all outputs to 0.
REQ-021 Reset asserted during BUSY SHALL abort the transaction, and no rN_ready SHALL be produced for it.

Configuration
REQ-022 Macro L2_ARB_PERF_EN SHALL control the performance counters.
- Defined: the block SHALL add outputs grant_cnt0 and grant_cnt1 (output 16 bits). Each SHALL count completed transactions (rN_ready pulses) per requester, saturate at 16'hFFFF, and reset to 0.
- Undefined: these ports and counters SHALL be absent, and behaviour SHALL otherwise be identical.

Structure
REQ-023 The shared package l2_pkg SHALL hold the FSM state typedef (IDLE, BUSY) and the requester-id width constant.
REQ-024 The sub-module rr_arb2 SHALL be a combinational 2-way round-robin picker: inputs req[1:0] and last_grant; outputs gnt_valid and gnt_id.

Verification
REQ-025 r0_read with r0_addr=32'h0000_1000, l2_ready after 3 cycles, l2_hit=1 -> l2_read=1 with l2_addr=32'h1000 from cycle+1 until l2_ready; r0_ready=1, r0_hit=1 and r0_rdata=l2_rdata in that cycle.
REQ-026 r0_read and r1_write asserted together after reset -> r0 served first, then r1; l2_write=1 with r1's addr/wdata on the second grant.
REQ-027 Both requesters asserting continuously for 6 transactions -> grant order 0,1,0,1,0,1.
REQ-028 r0 changes r0_addr from 32'h1000 to 32'h2000 during BUSY -> l2_addr stays 32'h1000.
REQ-029 rst_n pulsed low mid-BUSY -> all outputs 0 immediately, FSM in IDLE, no rN_ready; the next simultaneous request grants r0.
REQ-030 With L2_ARB_PERF_EN defined, 3 r1 transactions -> grant_cnt1=3 and grant_cnt0=0.
